// File: rtl/atm_bank_arbiter.sv
// Round-robin arbiter serialising balance query/deposit/withdraw from N_TERM terminals onto a shared account store.
// Optional build macro ATM_ARB_AUDIT_EN adds a saturating 16-bit count of successful transactions (txn_cnt).
module atm_bank_arbiter #(
  parameter int N_TERM   = 4,
  parameter int N_ACCT   = 8,
  parameter int ACCT_W   = 3,
  parameter int BAL_W    = 8,
  parameter int INIT_BAL = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_TERM-1:0]        req,
  input  logic [2*N_TERM-1:0]      op,
  input  logic [ACCT_W*N_TERM-1:0] acct,
  input  logic [BAL_W*N_TERM-1:0]  amount,
  output logic [N_TERM-1:0]        gnt,
  output logic                     done,
  output logic [BAL_W-1:0]         resp_bal,
  output logic                     resp_err
`ifdef ATM_ARB_AUDIT_EN
  ,
  output logic [15:0]              txn_cnt
`endif
);

  localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, DONE} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic [BAL_W-1:0]   mem_q [N_ACCT];

  logic [1:0]         op_q;
  logic [ACCT_W-1:0]  acct_q;
  logic [BAL_W-1:0]   amt_q;
  logic [BAL_W-1:0]   bal_q;
  logic [BAL_W-1:0]   new_q;
  logic               err_q;

  logic               any_req;
  logic [PTR_W-1:0]   win_d;
  logic [PTR_W-1:0]   cand;
  logic [1:0]         sel_op;
  logic [ACCT_W-1:0]  sel_acct;
  logic [BAL_W-1:0]   sel_amt;
  logic [BAL_W-1:0]   rd_bal;
  logic               acct_ok;

  // Returns {err, new_balance}; any rejected operation leaves the old balance in place.
  function automatic logic [BAL_W:0] exec_op(input logic [1:0] op_f, input logic ok,
                                             input logic [BAL_W-1:0] old,
                                             input logic [BAL_W-1:0] amt);
    logic [BAL_W:0] sum;
    sum     = {1'b0, old} + {1'b0, amt};
    exec_op = {1'b1, old};
    if (ok) begin
      case (op_f)
        2'b00:   exec_op = {1'b0, old};
        2'b01:   if (!sum[BAL_W]) exec_op = {1'b0, sum[BAL_W-1:0]};
        2'b10:   if (amt <= old) exec_op = {1'b0, old - amt};
        default: exec_op = {1'b1, old};
      endcase
    end
  endfunction

`ifdef ATM_ARB_AUDIT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Scan downward so the candidate closest to rr_ptr_q is the last (winning) assignment.
  always_comb begin
    any_req = 1'b0;
    win_d   = rr_ptr_q;
    cand    = '0;
    for (int k = N_TERM - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_TERM);
      if (req[cand]) begin
        any_req = 1'b1;
        win_d   = cand;
      end
    end
  end

  always_comb begin
    sel_op   = '0;
    sel_acct = '0;
    sel_amt  = '0;
    for (int t = 0; t < N_TERM; t++) begin
      if (win_d == PTR_W'(t)) begin
        sel_op   = op[2*t +: 2];
        sel_acct = acct[ACCT_W*t +: ACCT_W];
        sel_amt  = amount[BAL_W*t +: BAL_W];
      end
    end
  end

  // Out-of-range accounts read as zero and are flagged for rejection.
  always_comb begin
    rd_bal  = '0;
    acct_ok = 1'b0;
    for (int a = 0; a < N_ACCT; a++) begin
      if (acct_q == ACCT_W'(a)) begin
        rd_bal  = mem_q[a];
        acct_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_q   <= sel_op;
          acct_q <= sel_acct;
          amt_q  <= sel_amt;
        end
      end
      LOOKUP:  bal_q <= rd_bal;
      EXEC:    {err_q, new_q} <= exec_op(op_q, acct_ok, bal_q, amt_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      resp_bal <= '0;
      resp_err <= 1'b0;
      for (int a = 0; a < N_ACCT; a++) mem_q[a] <= BAL_W'(INIT_BAL);
`ifdef ATM_ARB_AUDIT_EN
      txn_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q   <= win_d;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          gnt     <= N_TERM'(1) << win_q;
          state_q <= EXEC;
        end
        EXEC: state_q <= DONE;
        DONE: begin
          if (!err_q) begin
            for (int a = 0; a < N_ACCT; a++)
              if (acct_q == ACCT_W'(a)) mem_q[a] <= new_q;
          end
          done     <= 1'b1;
          resp_bal <= new_q;
          resp_err <= err_q;
          rr_ptr_q <= (win_q == PTR_W'(N_TERM - 1)) ? '0 : win_q + 1'b1;
          gnt      <= '0;
`ifdef ATM_ARB_AUDIT_EN
          if (!err_q) txn_cnt <= sat_inc16(txn_cnt);
`endif
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_arbiter.sv
// Randomised self-checking bench for atm_bank_arbiter against a transaction-level bank model.
module tb_atm_bank_arbiter;

  localparam int NT = 4;
  localparam int NA = 6;
  localparam int AW = 3;
  localparam int BW = 8;
  localparam int IB = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NT-1:0]     req;
  logic [2*NT-1:0]   op;
  logic [AW*NT-1:0]  acct;
  logic [BW*NT-1:0]  amount;
  logic [NT-1:0]     gnt;
  logic              done;
  logic [BW-1:0]     resp_bal;
  logic              resp_err;
`ifdef ATM_ARB_AUDIT_EN
  logic [15:0]       txn_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int mbal [NA];
  int mrr;
  int mcnt;
  int f_op [NT];
  int f_acct [NT];
  int f_amt [NT];

  atm_bank_arbiter #(
    .N_TERM(NT), .N_ACCT(NA), .ACCT_W(AW), .BAL_W(BW), .INIT_BAL(IB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .acct(acct), .amount(amount),
    .gnt(gnt), .done(done), .resp_bal(resp_bal), .resp_err(resp_err)
`ifdef ATM_ARB_AUDIT_EN
    , .txn_cnt(txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) mbal[a] = IB;
    mrr  = 0;
    mcnt = 0;
  endtask

  function automatic int pick(input logic [NT-1:0] pend);
    for (int k = 0; k < NT; k++)
      if (pend[(mrr + k) % NT]) return (mrr + k) % NT;
    return -1;
  endfunction

  task automatic model_exec(input int w, output int eb, output int ee);
    int o, a, m, old;
    o = f_op[w]; a = f_acct[w]; m = f_amt[w];
    if (a >= NA) begin
      eb = 0; ee = 1;
    end else begin
      old = mbal[a]; eb = old; ee = 1;
      if (o == 0) ee = 0;
      else if (o == 1 && old + m <= 255) begin eb = old + m; ee = 0; end
      else if (o == 2 && m <= old) begin eb = old - m; ee = 0; end
      if (ee == 0) mbal[a] = eb;
    end
    if (ee == 0 && mcnt < 65535) mcnt++;
  endtask

  task automatic set_f(input int t, input int o, input int a, input int m);
    f_op[t] = o; f_acct[t] = a; f_amt[t] = m;
    op[2*t +: 2]      = 2'(o);
    acct[AW*t +: AW]  = 3'(a);
    amount[BW*t +: BW] = 8'(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Raise all requests in mask together; each holds until its own done.
  task automatic run_batch(input logic [NT-1:0] mask);
    logic [NT-1:0] pend;
    int cyc, served, phase, w, eb, ee;
    pend = mask;
    req = mask;
    cyc = 0; served = 0;
    w = pick(pend);
    while (pend != 0 && cyc < 4*NT + 8) begin
      @(negedge clk);
      cyc++;
      phase = cyc - 4*served;
      if (phase == 1) check("gnt_early", gnt, 0);
      if (phase == 2) begin
        check("gnt", gnt, 32'(1) << w);
        op[2*w +: 2]       = 2'($urandom);
        acct[AW*w +: AW]   = 3'($urandom);
        amount[BW*w +: BW] = 8'($urandom);
      end
      if (phase == 3) check("done_early", done, 0);
      if (phase == 4) begin
        check("done", done, 1);
        model_exec(w, eb, ee);
        check("resp_bal", resp_bal, eb);
        check("resp_err", resp_err, ee);
`ifdef ATM_ARB_AUDIT_EN
        check("txn_cnt", txn_cnt, mcnt);
`endif
        pend[w] = 1'b0;
        req[w]  = 1'b0;
        served++;
        mrr = (w + 1) % NT;
        if (pend != 0) w = pick(pend);
      end
    end
    if (pend != 0) check("timeout_pending", pend, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("gnt_idle", gnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; op = '0; acct = '0; amount = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_bal", resp_bal, 0);
    check("rst_err", resp_err, 0);
`ifdef ATM_ARB_AUDIT_EN
    check("rst_txn", txn_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    set_f(0, 0, 2, 0);   run_batch(4'b0001);
    set_f(1, 1, 3, 200); run_batch(4'b0010);
    set_f(1, 1, 3, 155); run_batch(4'b0010);
    set_f(2, 2, 1, 100); run_batch(4'b0100);
    set_f(2, 2, 1, 1);   run_batch(4'b0100);

    do_reset();
    set_f(0, 0, 0, 0);
    set_f(1, 1, 1, 5);
    set_f(2, 2, 2, 10);
    set_f(3, 0, 5, 0);
    run_batch(4'b1111);
`ifdef ATM_ARB_AUDIT_EN
    check("txn_cnt_four", txn_cnt, 4);
`endif

    set_f(3, 3, 0, 7);   run_batch(4'b1000);
    set_f(0, 0, 7, 0);   run_batch(4'b0001);
    set_f(1, 0, 0, 0);   run_batch(4'b0010);

    for (int b = 0; b < 40; b++) begin
      for (int t = 0; t < NT; t++)
        set_f(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      run_batch(NT'($urandom_range(1, 15)));
    end

    // Reset lands while the withdraw sits in EXEC; its write must never happen.
    set_f(2, 2, 4, 50);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("gnt_pre_rst", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_done", done, 0);
    req = '0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    set_f(2, 0, 4, 0);
    run_batch(4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/atm_bank_arbiter.md
# atm_bank_arbiter

Shared account-balance store and round-robin arbiter for multiple ATM terminal front ends. Each terminal FSM raises a request carrying an operation (balance query, deposit, withdraw), an account index and an amount. The arbiter grants one terminal at a time and performs the read-modify-write on the shared balance array with overflow and insufficient-funds checking. It returns the resulting balance and an error flag. It sits between the per-terminal session controllers and the account storage, serialising all balance accesses.

## Interface
- `N_TERM`, 4 — number of requesting terminals (2..8).
- `N_ACCT`, 8 — number of accounts held.
- `ACCT_W`, 3 — account index width; `2**ACCT_W >= N_ACCT`.
- `BAL_W`, 8 — balance/amount width.
- `INIT_BAL`, 100 — balance loaded into every account on reset.

- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req`  in  N_TERM  — per-terminal request, level.
- `op`  in  2*N_TERM  — per-terminal op, slice i = `[2i+1:2i]`: 00 query, 01 deposit, 10 withdraw, 11 illegal.
- `acct`  in  ACCT_W*N_TERM  — per-terminal account index.
- `amount`  in  BAL_W*N_TERM  — per-terminal amount; ignored for query.
- `gnt`  out  N_TERM  — one-hot grant; high from LOOKUP through DONE.
- `done`  out  1  — one-cycle completion pulse.
- `resp_bal`  out  BAL_W  — balance after the operation; valid while `done`=1.
- `resp_err`  out  1  — operation rejected; valid while `done`=1.
- `txn_cnt`  out  16  — present only with `ATM_ARB_AUDIT_EN`.

## Operation
- FSM states are IDLE, LOOKUP, EXEC and DONE.
- **IDLE:** if any `req` bit is high, pick the winner with round-robin priority. The search starts at `rr_ptr` and ascends with wrap. Capture the winner's op, acct and amount into registers, then go to LOOKUP. With no request, stay in IDLE.
- **LOOKUP:** assert `gnt[winner]` and read the stored balance into `bal_q`. Go to EXEC.
- **EXEC:** compute the new balance and the error flag, and write back only when there is no error. Go to DONE.
  - Query: new = old, err = 0.
  - Deposit: compute the sum at BAL_W+1 bits. If the carry is set, err = 1 and the balance is unchanged; otherwise write back the sum.
  - Withdraw: if amount > old, err = 1 and the balance is unchanged. If amount <= old, write old − amount; amount == old yields 0.
  - Illegal op (11) or acct >= N_ACCT: err = 1, no write. `resp_bal` = old balance, or 0 if acct is out of range.
- **DONE:** `done` = 1, and `resp_bal`/`resp_err` are driven from registers. Set `rr_ptr` = (winner+1) mod N_TERM, drop `gnt`, and go to IDLE.
- Captured fields are frozen from IDLE→LOOKUP onward. Changing or dropping `req`, `op`, `acct` or `amount` mid-transaction does not abort the transaction or alter its result.
- A requester must deassert `req` in the cycle after `done`. A `req` still high in IDLE is arbitrated as a new transaction. Because `rr_ptr` has advanced, other pending terminals win first.

## Timing
- Reset (`rst_n` low, asynchronous, at any state including mid-transaction):
  - FSM returns to IDLE.
  - `gnt` = 0, `done` = 0, `resp_bal` = 0, `resp_err` = 0, `rr_ptr` = 0.
  - All balances are set to INIT_BAL.
  - An interrupted write is discarded.
- Latency: `req` sampled high at edge k (FSM in IDLE) gives `gnt` high after edge k+1, writeback at edge k+3, and `done` high for exactly the cycle after edge k+3.
- Throughput: one transaction per 4 cycles. Back-to-back requests from different terminals produce a `done` every 4th cycle.
- Simultaneous requests resolve strictly by `rr_ptr`. No terminal waits more than N_TERM−1 transactions.
- `gnt` and `done` never assert for more than one terminal or one cycle respectively.

## Configuration
- `ATM_ARB_AUDIT_EN` defined:
  - Adds `txn_cnt`, a 16-bit register, reset to 0.
  - It increments at the DONE cycle of every transaction with `resp_err` = 0, including queries.
  - It saturates at 16'hFFFF.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset, then terminal 0 queries acct 2 → `gnt`=0001 one cycle after `req`, `done` three cycles later, `resp_bal`=100, `resp_err`=0.
- Terminal 1 deposits 200 to acct 3 (balance 100) → `resp_err`=1, `resp_bal`=100, balance unchanged. A following deposit of 155 gives `resp_bal`=255, `resp_err`=0.
- Withdraw sequence on acct 1 (balance 100):
  - withdraw 100 → `resp_bal`=0, `resp_err`=0.
  - then withdraw 1 → `resp_err`=1, `resp_bal`=0.
- All four `req` high on the same edge after reset, each held until its own `done` → grants served in order 0,1,2,3, four `done` pulses spaced 4 cycles apart. With the audit macro defined and no errors, `txn_cnt`=4.
- Illegal op 11, and acct 7 ≥ N_ACCT=6 → both give `resp_err`=1 with no balance change.
- Withdraw in progress, assert `rst_n` low during EXEC → `gnt`=0 and `done`=0 immediately; after release, querying that account returns 100.
